// File: rtl/mat_loader.sv
// Stream-to-Q_RAM write front end: loads matrix 1 then matrix 2, then pulses done.
// Optional MAT_LOADER_CONJ_EN: saturating negation of matrix-2 imaginary data.
`ifndef WORD_LEN
`define WORD_LEN 16
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 4
`endif

module mat_loader #(
   parameter int WORD_LEN  = `WORD_LEN,
   parameter int ADDR_BITS = `ADDR_BITS,
   parameter int DEPTH     = 2**`ADDR_BITS
) (
   input  logic                       src_clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic signed [WORD_LEN-1:0] in_real,
   input  logic signed [WORD_LEN-1:0] in_imag,
   output logic [3:0]                 we,
   output logic [ADDR_BITS-1:0]       Dir_M1,
   output logic [ADDR_BITS-1:0]       Dir_M2,
   output logic signed [WORD_LEN-1:0] data_m1_real,
   output logic signed [WORD_LEN-1:0] data_m1_imag,
   output logic signed [WORD_LEN-1:0] data_m2_real,
   output logic signed [WORD_LEN-1:0] data_m2_imag,
   output logic                       busy,
   output logic                       done
);

   typedef enum logic [1:0] {IDLE, LOAD_M1, LOAD_M2, DONE} state_t;

   state_t                       state, next_state;
   logic [ADDR_BITS-1:0]         count;
   logic                         beat;
   logic                         last;
   logic signed [WORD_LEN-1:0]   m2_imag;

   assign busy     = (state == LOAD_M1) || (state == LOAD_M2);
   assign done     = (state == DONE);
   assign in_ready = busy;
   assign beat     = in_valid && busy;
   // Compare against DEPTH-1 so non-power-of-two depths wrap correctly
   assign last     = (count == ADDR_BITS'(DEPTH - 1));

`ifdef MAT_LOADER_CONJ_EN
   localparam logic signed [WORD_LEN-1:0] MIN_VAL = {1'b1, {(WORD_LEN-1){1'b0}}};
   assign m2_imag = (in_imag == MIN_VAL) ? ~MIN_VAL : -in_imag;
`else
   assign m2_imag = in_imag;
`endif

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = LOAD_M1;
         LOAD_M1: if (beat && last) next_state = LOAD_M2;
         LOAD_M2: if (beat && last) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge src_clk) begin
      if (!rst) begin
         state        <= IDLE;
         count        <= '0;
         we           <= '0;
         Dir_M1       <= '0;
         Dir_M2       <= '0;
         data_m1_real <= '0;
         data_m1_imag <= '0;
         data_m2_real <= '0;
         data_m2_imag <= '0;
      end else begin
         state <= next_state;
         we    <= 4'b0000;
         case (state)
            IDLE: if (start) count <= '0;
            LOAD_M1: if (beat) begin
               we           <= 4'b0011;
               Dir_M1       <= count;
               data_m1_real <= in_real;
               data_m1_imag <= in_imag;
               count        <= last ? '0 : count + ADDR_BITS'(1);
            end
            LOAD_M2: if (beat) begin
               we           <= 4'b1100;
               Dir_M2       <= count;
               data_m2_real <= in_real;
               data_m2_imag <= m2_imag;
               count        <= last ? '0 : count + ADDR_BITS'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/mat_loader.md
# mat_loader

Write-side front end for the complex matrix multiplier: accepts a valid/ready stream of complex elements and turns it into the per-matrix write-enable, address and data signals consumed by the coefficient datapath's Q_RAM. On `start` it loads all of matrix 1, then all of matrix 2, and pulses `done`. When idle it holds `we` at 4'b0000, which hands RAM addressing back to the internal memory manager.

## Interface
- `WORD_LEN`, default `` `WORD_LEN ``: sample word width (signed, two's complement).
- `ADDR_BITS`, default `` `ADDR_BITS ``: RAM address width.
- `DEPTH`, default 2**`ADDR_BITS`: elements per matrix; valid range 2..2**`ADDR_BITS`.
- Clocking and reset: one clock; reset is synchronous and active-low.
- `src_clk` input 1: the single clock; all logic is on its rising edge.
- `rst` input 1: synchronous, active-low reset.
- `start` input 1: one-cycle request to begin a load; only honoured in IDLE.
- `in_valid` input 1: a stream element is present.
- `in_ready` output 1: the loader accepts the element this cycle.
- `in_real`, `in_imag` input WORD_LEN: element value (signed).
- `we` output 4: bit0 M1 real, bit1 M1 imag, bit2 M2 real, bit3 M2 imag.
- `Dir_M1`, `Dir_M2` output ADDR_BITS: write addresses.
- `data_m1_real`, `data_m1_imag`, `data_m2_real`, `data_m2_imag` output WORD_LEN: write data.
- `busy` output 1: high in LOAD_M1 and LOAD_M2.
- `done` output 1: one-cycle pulse when a load completes.

## Operation
- FSM states: IDLE, LOAD_M1, LOAD_M2, DONE.
  - IDLE → LOAD_M1 on `start`. The address counter clears to 0.
  - LOAD_M1 → LOAD_M2 on the beat that is accepted at count DEPTH-1. The counter returns to 0.
  - LOAD_M2 → DONE on the beat that is accepted at count DEPTH-1.
  - DONE → IDLE unconditionally after one cycle.
- `in_ready` = `busy`. A beat is a cycle with `in_valid` and `in_ready` both high.
- On each beat the outputs are registered for one cycle:
  - In LOAD_M1: `we` = 4'b0011, `Dir_M1` = count, `data_m1_real` = `in_real`, `data_m1_imag` = `in_imag`.
  - In LOAD_M2: `we` = 4'b1100, `Dir_M2` = count, with the matching M2 data.
  - The counter then increments.
- In any cycle without a beat, `we` = 4'b0000. Address and data registers hold their last value.
- `start` while busy or in DONE is ignored. It does not restart or queue a load.
- `in_valid` outside LOAD states is not accepted and produces no write.
- Gaps in `in_valid` stall the load. The counter and state hold.

## Timing
- Reset (`rst`=0 at a clock edge) forces:
  - state = IDLE, counter = 0;
  - `we` = 0, `busy` = 0, `done` = 0, `in_ready` = 0;
  - `Dir_M1` = `Dir_M2` = 0 and all data outputs = 0.
- Reset in the middle of a load aborts it. No `done` is produced, and a partial matrix remains in RAM.
- Write latency: a beat at edge N drives `we`/address/data during cycle N+1 (one cycle), written at edge N+1.
- Throughput: one element per cycle. A full load is at least 2·DEPTH beat cycles.
- `busy` rises the cycle after `start` is sampled.
- `done` is high in the DONE state. That is the cycle in which the last M2 write (`we` = 4'b1100, `Dir_M2` = DEPTH-1) is on the outputs.
- `busy` is low in DONE. `we` returns to 0000 the cycle after DONE.
- The counter compares to DEPTH-1, never to 2**ADDR_BITS, so it wraps correctly for non-power-of-two DEPTH.

## Configuration
- `MAT_LOADER_CONJ_EN`:
  - When defined, matrix-2 imaginary data is negated before it is written (conjugate load, for A·Bᴴ products).
  - The negation saturates: -(-2^(WORD_LEN-1)) writes 2^(WORD_LEN-1)-1.
  - Matrix-1 data and all real parts pass unchanged.
  - When undefined, M2 imaginary is written verbatim. The datapath is identical apart from this.

## Test plan
- Reset then full load:
  - Stimulus: `rst`=0 for 2 cycles, `start`, then 2·DEPTH back-to-back beats with real=k, imag=-k.
  - Response, M1 phase: `we`=0011 with `Dir_M1`=0..DEPTH-1 in order.
  - Response, M2 phase: `we`=1100 with `Dir_M2`=0..DEPTH-1; `done` exactly once, coincident with address DEPTH-1; `busy` low afterwards.
- Stalls: random `in_valid` gaps during both phases → address sequence is unchanged with no skips or repeats; `we`=0000 on every gap cycle.
- Ignored requests: `start` pulsed mid-LOAD_M1 and `in_valid` asserted in IDLE → no restart, no extra writes, `in_ready`=0 in IDLE.
- Reset mid-operation: `rst`=0 after 5 beats of M2 → next cycle `we`=0, `busy`=0, all outputs 0, no `done`. A subsequent `start` restarts at M1 address 0.
- Conjugation with `MAT_LOADER_CONJ_EN`:
  - Stimulus: M2 imag values 5, -3, and -2^(WORD_LEN-1).
  - Response: written as -5, 3, and 2^(WORD_LEN-1)-1.
  - Without the macro, the same values are written verbatim; M1 is unaffected in both builds.
- Non-power-of-two DEPTH (e.g. 6 with ADDR_BITS=3) → addresses 0..5 per matrix, then phase change; address 6 or 7 never appears.
